// File: rtl/ram_backing_ctrl.sv
// Word-wide backing RAM behind the cache: one request at a time; completes READ_LATENCY or WRITE_LATENCY cycles after the request is sampled.
// No backpressure: requests are sampled only in IDLE, and ram_busy covers the whole in-flight window.
module ram_backing_ctrl #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int MEM_WORDS     = 2 ** (ADDRESS_WIDTH - 2),
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ram_rd,
  input  logic                     ram_wr,
  input  logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic [31:0]              ram_data_wr,
  output logic [31:0]              ram_data_rd,
  output logic                     ram_data_valid,
  output logic                     ram_busy,
  output logic [CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]     wr_count,
  output logic                     err_sticky
);

  localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  if (READ_LATENCY < 1) begin : g_bad_read_latency
    $fatal(1, "ram_backing_ctrl: READ_LATENCY must be >= 1");
  end
  if (WRITE_LATENCY < 1) begin : g_bad_write_latency
    $fatal(1, "ram_backing_ctrl: WRITE_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR, RESPOND} state_t;

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          wdat_q, wdat_d;
  logic [31:0]          rdat_q, rdat_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic [IDX_W-1:0]     req_idx;
  logic [31:0]          mem [MEM_WORDS];

  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, ram_address[1:0]};

  assign req_idx = IDX_W'(32'(ram_address[ADDRESS_WIDTH-1:2]) % 32'(MEM_WORDS));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    valid_d  = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_wr && !ram_rd) begin
          idx_d   = req_idx;
          wdat_d  = ram_data_wr;
          cnt_d   = LAT_W'(WRITE_LATENCY - 1);
          state_d = WAIT_WR;
        end else if (ram_rd && !ram_wr) begin
          idx_d   = req_idx;
          cnt_d   = LAT_W'(READ_LATENCY - 1);
          state_d = WAIT_RD;
        end else if (ram_rd && ram_wr) begin
          err_d = 1'b1;
        end
      end
      WAIT_RD: begin
        if (cnt_q == '0) begin
          rdat_d   = mem[idx_q];
          valid_d  = 1'b1;
          rd_cnt_d = (&rd_cnt_q) ? rd_cnt_q : rd_cnt_q + 1'b1;
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_WR: begin
        if (cnt_q == '0) begin
          // The write lands on the same edge that raises the valid pulse.
          mem_we   = 1'b1;
          valid_d  = 1'b1;
          wr_cnt_d = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + 1'b1;
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign ram_data_rd    = rdat_q;
  assign ram_data_valid = valid_q;
  assign ram_busy       = busy_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign err_sticky     = err_q;

endmodule
